// File: rtl/router_pkg.sv
// Shared types and constants for the router output path.
package router_pkg;

    localparam int FLIT_W   = 11;
    localparam int TAIL_BIT = FLIT_W - 1;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } alloc_state_t;

endpackage

// File: rtl/output_allocator_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping cyclically.
module rr_arbiter #(
    parameter int NUM_IN = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic [NUM_IN-1:0] grant_oh,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_vld
);

    int   cand_s;
    logic hit_s;

    // Scan candidates in priority order starting from rr_ptr; the first hit wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand_s    = 0;
        hit_s     = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand_s = int'(rr_ptr) + k;
            cand_s = (cand_s >= NUM_IN) ? (cand_s - NUM_IN) : cand_s;
            hit_s  = ~grant_vld & req[cand_s];
            grant_idx        = hit_s ? IDX_W'(cand_s) : grant_idx;
            grant_oh[cand_s] = grant_oh[cand_s] | hit_s;
            grant_vld        = grant_vld | hit_s;
        end
    end

endmodule

// File: rtl/output_allocator.sv
// Per-output packet-granular round-robin allocator feeding the output link FIFO.
// Optional OUTPUT_ALLOC_PKT_CNT_EN adds a saturating 16-bit count of tail flits written.
module output_allocator #(
    parameter int NUM_IN = 2,
    parameter int FLIT_W = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        req,
    input  logic [NUM_IN*FLIT_W-1:0] data_in,
    output logic [NUM_IN-1:0]        ready,
    input  logic                     fifo_full,
    output logic                     wr_en,
    output logic [FLIT_W-1:0]        data_out
`ifdef OUTPUT_ALLOC_PKT_CNT_EN
    ,
    output logic [15:0]              pkt_count
`endif
);
    import router_pkg::*;

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int TAIL  = FLIT_W - 1;

    alloc_state_t      state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d, rr_ptr_q, rr_ptr_d, arb_idx_s;
    logic [NUM_IN-1:0] grant_oh_q, grant_oh_d, arb_oh_s, ready_s;
    logic              arb_vld_s, accept_s, tail_s, wr_en_q, wr_en_d;
    logic [FLIT_W-1:0] data_out_q, data_out_d, cur_flit_s;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_rr_arbiter (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (arb_oh_s),
        .grant_idx (arb_idx_s),
        .grant_vld (arb_vld_s)
    );

    // Flit presented by the currently granted input.
    always_comb begin
        cur_flit_s = data_in[int'(grant_q)*FLIT_W +: FLIT_W];
    end

    // Next-state and handshake logic; the grant is only released by an accepted tail.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        rr_ptr_d   = rr_ptr_q;
        wr_en_d    = 1'b0;
        data_out_d = data_out_q;
        ready_s    = '0;
        accept_s   = 1'b0;
        tail_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_vld_s) begin
                    grant_d    = arb_idx_s;
                    grant_oh_d = arb_oh_s;
                    state_d    = BUSY;
                end else begin
                    state_d    = IDLE;
                end
            end
            BUSY: begin
                ready_s  = grant_oh_q & {NUM_IN{~fifo_full}};
                accept_s = |(ready_s & req);
                tail_s   = cur_flit_s[TAIL];
                if (accept_s) begin
                    wr_en_d    = 1'b1;
                    data_out_d = cur_flit_s;
                    if (tail_s) begin
                        rr_ptr_d = (grant_q == IDX_W'(NUM_IN - 1)) ? '0 : grant_q + IDX_W'(1);
                        state_d  = IDLE;
                    end else begin
                        state_d  = BUSY;
                    end
                end else begin
                    wr_en_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_ptr_q   <= '0;
            wr_en_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_en_q    <= wr_en_d;
            data_out_q <= data_out_d;
        end
    end

    assign ready    = ready_s;
    assign wr_en    = wr_en_q;
    assign data_out = data_out_q;

`ifdef OUTPUT_ALLOC_PKT_CNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    // Counts on the same edge the tail write is registered; sticks at all-ones.
    always_comb begin
        if (accept_s && tail_s && (pkt_cnt_q != 16'hFFFF)) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    // Packet counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt_q <= 16'd0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_output_allocator.sv
// Self-checking bench for output_allocator: per-cycle model comparison plus directed literal checks.
module tb_output_allocator;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [21:0] data_in;
    logic [1:0]  ready;
    logic        fifo_full;
    logic        wr_en;
    logic [10:0] data_out;
`ifdef OUTPUT_ALLOC_PKT_CNT_EN
    logic [15:0] pkt_count;
`endif

    output_allocator #(
        .NUM_IN (2),
        .FLIT_W (11)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .ready     (ready),
        .fifo_full (fifo_full),
        .wr_en     (wr_en),
        .data_out  (data_out)
`ifdef OUTPUT_ALLOC_PKT_CNT_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [1:0]  stall;
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] log_d[$];
    int          log_c[$];

    // Behavioural model: owner of the output (-1 = none), round-robin pointer, expected write.
    int          m_owner;
    int          m_ptr;
    logic        m_wr;
    logic [10:0] m_data;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk or negedge reset) begin : model
        int o;
        int p;
        int c;
        logic w;
        logic [10:0] d;
        logic [10:0] f;
        if (!reset) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_wr    <= 1'b0;
            m_data  <= 11'h000;
        end else begin
            o = m_owner;
            p = m_ptr;
            w = 1'b0;
            d = m_data;
            if (o < 0) begin
                for (int k = 0; k < 2; k++) begin
                    c = (p + k) % 2;
                    if (o < 0 && req[c]) o = c;
                end
            end else if (!fifo_full && req[o]) begin
                f = (o == 0) ? data_in[10:0] : data_in[21:11];
                w = 1'b1;
                d = f;
                if (f[10]) begin
                    p = (o + 1) % 2;
                    o = -1;
                end
            end
            m_owner <= o;
            m_ptr   <= p;
            m_wr    <= w;
            m_data  <= d;
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    initial begin
        logic [1:0] er;
        forever begin
            @(negedge clk);
            cyc++;
            er = 2'b00;
            if (m_owner >= 0 && !fifo_full) er[m_owner] = 1'b1;
            chk("ready", int'(ready), int'(er));
            chk("wr_en", int'(wr_en), int'(m_wr));
            chk("data_out", int'(data_out), int'(m_data));
            if (wr_en) begin
                log_d.push_back(data_out);
                log_c.push_back(cyc);
            end
        end
    end

    task automatic drive();
        req[0]  = (q0.size() > 0) && !stall[0];
        req[1]  = (q1.size() > 0) && !stall[1];
        data_in = {(q1.size() > 0) ? q1[0] : 11'h000, (q0.size() > 0) ? q0[0] : 11'h000};
    endtask

    task automatic step();
        logic [1:0] take;
        @(negedge clk);
        take = ready & req;
        @(posedge clk);
        #1;
        if (take[0]) void'(q0.pop_front());
        if (take[1]) void'(q1.pop_front());
        drive();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 200) begin
            step();
            n++;
        end
        chk("drain_in_budget", int'(n < 200), 1);
        repeat (4) step();
    endtask

    task automatic chk_log(input string nm, input int n, input int e0, input int e1,
                           input int e2, input int e3, input int e4);
        int e[5];
        e = '{e0, e1, e2, e3, e4};
        chk({nm, "_count"}, log_d.size(), n);
        for (int i = 0; i < n && i < log_d.size(); i++) chk(nm, int'(log_d[i]), e[i]);
    endtask

    task automatic clr_log();
        log_d.delete();
        log_c.delete();
    endtask

    initial begin
        reset     = 1'b0;
        fifo_full = 1'b0;
        stall     = 2'b00;
        // Reset with both inputs requesting; these queues are the contention packets.
        q0 = '{11'h011, 11'h412};
        q1 = '{11'h021, 11'h422};
        drive();
        repeat (2) step();
        chk("reset_ready", int'(ready), 0);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_data_out", int'(data_out), 0);
        clr_log();
        reset = 1'b1;

        // Contention: whole packet from input 0, bubble, then input 1.
        drain();
        chk_log("contention", 4, 'h011, 'h412, 'h021, 'h422, 0);
        if (log_c.size() == 4) begin
            chk("contention_back_to_back", log_c[1] - log_c[0], 1);
            chk("contention_bubble", log_c[2] - log_c[1], 2);
        end

        // Single input, three-flit packet.
        clr_log();
        q0 = '{11'h005, 11'h006, 11'h407};
        drive();
        drain();
        chk_log("single_input", 3, 'h005, 'h006, 'h407, 0, 0);

        // Backpressure mid-packet for four cycles.
        clr_log();
        q0 = '{11'h031, 11'h032, 11'h033, 11'h434};
        drive();
        repeat (2) step();
        fifo_full = 1'b1;
        drive();
        repeat (4) begin
            step();
            chk("full_ready", int'(ready), 0);
        end
        fifo_full = 1'b0;
        drive();
        drain();
        chk_log("backpressure", 4, 'h031, 'h032, 'h033, 'h434, 0);

        // Upstream stall: rr_ptr is 1 here, so input 1 wins and keeps the grant.
        clr_log();
        q1 = '{11'h051, 11'h052, 11'h453};
        q0 = '{11'h041, 11'h442};
        drive();
        repeat (2) step();
        stall[1] = 1'b1;
        drive();
        repeat (3) begin
            step();
            chk("stall_other_ready", int'(ready[0]), 0);
        end
        stall[1] = 1'b0;
        drive();
        drain();
        chk_log("upstream_stall", 5, 'h051, 'h052, 'h453, 'h041, 'h442);

        // Single-flit packets on both inputs with rr_ptr=1: input 1 first.
        clr_log();
        q0 = '{11'h461};
        q1 = '{11'h471};
        drive();
        drain();
        chk_log("single_flit", 2, 'h471, 'h461, 0, 0, 0);
        if (log_c.size() == 2) chk("single_flit_bubble", log_c[1] - log_c[0], 2);

`ifdef OUTPUT_ALLOC_PKT_CNT_EN
        reset = 1'b0;
        drive();
        step();
        chk("cnt_reset", int'(pkt_count), 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            q0.push_back(11'h400 + 11'(i));
            drive();
            drain();
        end
        chk("cnt_five", int'(pkt_count), 5);
        force dut.pkt_cnt_q = 16'hFFFF;
        step();
        release dut.pkt_cnt_q;
        q0.push_back(11'h4AA);
        drive();
        drain();
        chk("cnt_saturate", int'(pkt_count), 'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
